// File: rtl/dot_pkg.sv
// dot_pkg: shared constants and types for the dot-product word stream.
package dot_pkg;
    localparam int DOT_WIDTH     = 8;
    localparam int DOT_NUM_ELEM  = 3;
    localparam int DOT_FRAME_LEN = 6;
    localparam int DOT_RES_W     = 2 * DOT_WIDTH + 2;

    typedef logic [2:0] dot_slot_t;

    typedef struct packed {
        logic [DOT_NUM_ELEM-1:0][DOT_WIDTH-1:0] b;
        logic [DOT_NUM_ELEM-1:0][DOT_WIDTH-1:0] a;
    } dot_pair_t;
endpackage

// File: rtl/dot_stream_tx_if.sv
// dot_stream_tx_if: vector-pair input and result handshakes of dot_stream_tx.
interface dot_stream_tx_if #(
    parameter int WIDTH = dot_pkg::DOT_WIDTH,
    parameter int RES_W = 2 * WIDTH + 2
);
    logic               in_valid;
    logic               in_ready;
    logic [3*WIDTH-1:0] in_a;
    logic [3*WIDTH-1:0] in_b;
    logic               res_valid;
    logic               res_ready;
    logic [RES_W-1:0]   res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/dot_tx_fifo.sv
// dot_tx_fifo: synchronous FIFO of vector pairs with full/empty flags.
module dot_tx_fifo
    import dot_pkg::*;
#(
    parameter type T     = dot_pair_t,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
            if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/dot_stream_tx.sv
// dot_stream_tx: emits vector pairs as six-word frames aligned to the consumer's slot counter
// and returns real-frame results; DOT_TX_CHECK_EN adds a local reference check.
module dot_stream_tx
    import dot_pkg::*;
#(
    parameter int WIDTH      = DOT_WIDTH,
    parameter int FIFO_DEPTH = 2,
    parameter int RES_W      = 2 * WIDTH + 2
) (
    input  logic             clk,
    input  logic             reset,
    dot_stream_tx_if.slave   bus,
    output logic [WIDTH-1:0] tx_word,
    input  logic [RES_W-1:0] cons_dout,
    input  logic             cons_run,
    output logic             res_ovf,
    output logic             chk_mismatch
);
    typedef struct packed {
        logic [DOT_NUM_ELEM-1:0][WIDTH-1:0] b;
        logic [DOT_NUM_ELEM-1:0][WIDTH-1:0] a;
    } pair_t;

    dot_slot_t slot;
    pair_t     frame, head, in_pair;
    logic      frame_real, done_real, empty, full, load, cap;

    assign in_pair.a    = bus.in_a;
    assign in_pair.b    = bus.in_b;
    assign bus.in_ready = !full;
    assign load         = slot == dot_slot_t'(DOT_FRAME_LEN - 1);
    assign cap          = slot == '0 && cons_run && done_real;
    assign tx_word      = slot < dot_slot_t'(DOT_NUM_ELEM) ? frame.a[slot[1:0]]
                        : frame.b[2'(slot - dot_slot_t'(DOT_NUM_ELEM))];

    dot_tx_fifo #(.T(pair_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.in_valid),
        .pop   (load),
        .din   (in_pair),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // An empty FIFO at the frame edge sends an all-zero filler frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot       <= '0;
            frame      <= '0;
            frame_real <= 1'b0;
            done_real  <= 1'b0;
        end else begin
            slot <= load ? '0 : slot + dot_slot_t'(1);
            if (load) begin
                frame      <= empty ? '0 : head;
                frame_real <= !empty;
                done_real  <= frame_real;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            res_ovf       <= 1'b0;
        end else begin
            if (cap && (!bus.res_valid || bus.res_ready)) begin
                bus.res_valid <= 1'b1;
                bus.res_data  <= cons_dout;
            end else if (bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end
            if (cap && bus.res_valid && !bus.res_ready) res_ovf <= 1'b1;
        end
    end

`ifdef DOT_TX_CHECK_EN
    logic [RES_W-1:0] ref_dot, frame_exp, done_exp;

    always_comb begin
        ref_dot = '0;
        for (int i = 0; i < DOT_NUM_ELEM; i++)
            ref_dot = ref_dot + RES_W'(head.a[i]) * RES_W'(head.b[i]);
    end

    // The reference travels one frame behind, in step with done_real.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_exp    <= '0;
            done_exp     <= '0;
            chk_mismatch <= 1'b0;
        end else begin
            if (load) begin
                frame_exp <= empty ? '0 : ref_dot;
                done_exp  <= frame_exp;
            end
            if (cap && cons_dout != done_exp) chk_mismatch <= 1'b1;
        end
    end
`else
    assign chk_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_dot_stream_tx.sv
// tb_dot_stream_tx: directed and random stimulus against a queue-based model of the frame stream.
module tb_dot_stream_tx;
    localparam int W     = 8;
    localparam int RW    = 18;
    localparam int DEPTH = 2;

    typedef struct {
        int          c;
        int unsigned v;
        bit          err;
    } due_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  tx_word;
    logic [RW-1:0] cons_dout = '0;
    logic          cons_run = 1'b0;
    logic          res_ovf, chk_mismatch;

    dot_stream_tx_if #(.WIDTH(W), .RES_W(RW)) bus ();

    dot_stream_tx #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .RES_W(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .tx_word      (tx_word),
        .cons_dout    (cons_dout),
        .cons_run     (cons_run),
        .res_ovf      (res_ovf),
        .chk_mismatch (chk_mismatch)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    bit          force_err = 1'b0;
    logic [47:0] pend[$];
    due_t        due[$];
    int unsigned obs[$];
    logic [47:0] cur;
    int          ts, cyc;
    bit          mv, movf, mchk;
    int unsigned md;

    function automatic int unsigned dotp(logic [47:0] p);
        dotp = 0;
        for (int i = 0; i < 3; i++) dotp += 32'(p[8*i+:8]) * 32'(p[8*(i+3)+:8]);
    endfunction

    function automatic logic [47:0] mk(int a1, int a2, int a3, int b1, int b2, int b3);
        return {8'(b3), 8'(b2), 8'(b1), 8'(a3), 8'(a2), 8'(a1)};
    endfunction

    // Consumer: shares the reset, collects six words, returns run/dout in the following slot 0.
    int          cslot = 0;
    bit          chave = 1'b0;
    int unsigned cval = 0;
    logic [W-1:0] cbuf [6];
    always @(negedge clk) begin
        if (reset) begin
            cslot = 0;
            chave = 1'b1;
            cval = 999;
            cons_run = 1'b1;
            cons_dout = RW'(cval);
        end else begin
            cons_run = chave && cslot == 0;
            if (cslot == 0) cons_dout = RW'(cval + (force_err ? 1 : 0));
            cbuf[cslot] = tx_word;
            if (cslot == 5) begin
                cval = 0;
                for (int i = 0; i < 3; i++) cval += 32'(cbuf[i]) * 32'(cbuf[i+3]);
            end
            cslot = cslot == 5 ? 0 : cslot + 1;
        end
    end

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic offer(logic [47:0] p);
        bus.in_a = p[23:0];
        bus.in_b = p[47:24];
        bus.in_valid = 1'b1;
    endtask

    task automatic tick();
        bit   pushed, cap, rr;
        due_t d;
        pushed = bus.in_valid && pend.size() < DEPTH;
        cap = due.size() > 0 && due[0].c == cyc;
        rr = bus.res_ready;
        @(posedge clk);
        #1;
        if (cap) begin
            d = due.pop_front();
            if (d.err) mchk = 1'b1;
            if (!mv || rr) begin
                mv = 1'b1;
                md = d.v;
            end else movf = 1'b1;
        end else if (mv && rr) mv = 1'b0;
        if (ts == 5) begin
            if (pend.size() > 0) begin
                cur = pend.pop_front();
                due.push_back('{cyc + 7, dotp(cur) + (force_err ? 1 : 0), force_err});
            end else cur = '0;
        end
        if (pushed) pend.push_back({bus.in_b, bus.in_a});
        cyc++;
        ts = ts == 5 ? 0 : ts + 1;
        check("tx_word", 32'(tx_word), 32'(cur[8*ts+:8]));
        check("in_ready", 32'(bus.in_ready), 32'(pend.size() < DEPTH));
        check("res_valid", 32'(bus.res_valid), 32'(mv));
        check("res_data", 32'(bus.res_data), md);
        check("res_ovf", 32'(res_ovf), 32'(movf));
        check("chk_mismatch", 32'(chk_mismatch), 32'(mchk));
        if (bus.res_valid) obs.push_back(32'(bus.res_data));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pend.delete();
        due.delete();
        cur = '0;
        ts = 0;
        cyc = 0;
        mv = 1'b0;
        md = 0;
        movf = 1'b0;
        mchk = 1'b0;
        check("rst_tx_word", 32'(tx_word), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_res_ovf", 32'(res_ovf), 0);
        check("rst_chk", 32'(chk_mismatch), 0);
    endtask

    task automatic to_slot(int s);
        while (ts != s) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] pl [3];
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.res_ready = 1'b1;
        do_reset();

        repeat (24) tick();
        check("idle_no_result", obs.size(), 0);

        to_slot(2);
        offer(mk(1, 2, 3, 4, 5, 6));
        tick();
        bus.in_valid = 1'b0;
        to_slot(0);
        for (int i = 0; i < 6; i++) begin
            check("single_word", 32'(tx_word), i + 1);
            tick();
        end
        check("single_e7_valid", 32'(bus.res_valid), 0);
        tick();
        check("single_e8_valid", 32'(bus.res_valid), 1);
        check("single_e8_data", 32'(bus.res_data), 32);

        pl[0] = mk(1, 1, 1, 1, 1, 1);
        pl[1] = mk(2, 3, 4, 5, 6, 7);
        pl[2] = mk(10, 20, 30, 1, 2, 3);
        obs.delete();
        to_slot(0);
        offer(pl[0]);
        tick();
        offer(pl[1]);
        tick();
        offer(pl[2]);
        check("full_ready_drop", 32'(bus.in_ready), 0);
        for (int n = 0; n < 12 && !bus.in_ready; n++) tick();
        check("full_ready_back", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        repeat (30) tick();
        check("b2b_count", obs.size(), 3);
        for (int i = 0; i < 3; i++)
            check("b2b_order", i < obs.size() ? obs[i] : 32'hffff_ffff, dotp(pl[i]));

        obs.delete();
        bus.res_ready = 1'b0;
        to_slot(0);
        offer(mk(255, 255, 255, 255, 255, 255));
        tick();
        tick();
        bus.in_valid = 1'b0;
        repeat (24) tick();
        check("ovf_data", 32'(bus.res_data), 195075);
        check("ovf_valid", 32'(bus.res_valid), 1);
        check("ovf_flag", 32'(res_ovf), 1);
        bus.res_ready = 1'b1;
        tick();
        check("ovf_cleared", 32'(bus.res_valid), 0);
        check("ovf_sticky", 32'(res_ovf), 1);

        obs.delete();
        to_slot(0);
        offer(mk(9, 8, 7, 6, 5, 4));
        tick();
        offer(mk(3, 3, 3, 3, 3, 3));
        tick();
        bus.in_valid = 1'b0;
        to_slot(0);
        to_slot(3);
        check("abort_real_word", 32'(tx_word), 6);
        do_reset();
        repeat (24) tick();
        check("abort_no_result", obs.size(), 0);

`ifdef DOT_TX_CHECK_EN
        force_err = 1'b1;
        obs.delete();
        to_slot(0);
        offer(mk(1, 2, 3, 4, 5, 6));
        tick();
        bus.in_valid = 1'b0;
        repeat (20) tick();
        check("chk_set", 32'(chk_mismatch), 1);
        check("chk_data", obs.size() > 0 ? obs[0] : 32'hffff_ffff, 33);
        force_err = 1'b0;
`endif

        for (int n = 0; n < 400; n++) begin
            bus.res_ready = $urandom_range(0, 3) != 0;
            bus.in_valid = $urandom_range(0, 1) == 1;
            bus.in_a = 24'($urandom);
            bus.in_b = 24'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dot_stream_tx.md
# dot_stream_tx

Transmitter end of the serial dot-product word stream. It accepts vector pairs (a, b) on a valid/ready handshake and emits them, one word per cycle, as the six-word frame a1, a2, a3, b1, b2, b3. The frame is aligned to the free-running six-slot counter of the dot-product consumer. It also collects the consumer's returned `dout`/`run` result and presents it on a valid/ready result port, discarding results of filler frames.

## Interface
- `WIDTH`, 8, element width in bits
- `FIFO_DEPTH`, 2, number of pending vector pairs buffered (≥1)
- `RES_W`, 2*WIDTH+2, result width (18 at default)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  vector pair offered
- `in_ready`  out  1  FIFO not full
- `in_a`  in  3*WIDTH  a1 in [WIDTH-1:0], a2 next, a3 top
- `in_b`  in  3*WIDTH  b1 in [WIDTH-1:0], b2 next, b3 top
- `tx_word`  out  WIDTH  serial word to consumer `din`
- `cons_dout`  in  RES_W  consumer result
- `cons_run`  in  1  consumer result strobe
- `res_valid`  out  1  result held
- `res_ready`  in  1  result accepted
- `res_data`  out  RES_W  dot product of a real frame
- `res_ovf`  out  1  sticky: a result was dropped
- `chk_mismatch`  out  1  sticky: returned result differed from the local reference (see Configuration)

## Operation
- Slot counter `slot` runs 0..5 and wraps every cycle unconditionally. `tx_word` = word `slot` of the frame register (combinational mux from registers).
- Frame-load edge: the edge ending slot 5. If the FIFO is non-empty, pop into the frame register and set `real`=1. Otherwise load an all-zero filler frame and set `real`=0.
- No bypass: a pair pushed on the frame-load edge is not loaded on that edge.
- At every frame-load edge, `done_real` <= `real`.
- Capture: in a cycle with `slot`==0, `cons_run`=1 and `done_real`=1, `cons_dout` is captured. `cons_run` in any other slot, or with `done_real`=0, is ignored.
- Result register:
  - `res_valid`&&`res_ready` clears `res_valid`.
  - Capture while `res_valid`&&!`res_ready`: the new result is dropped, the old one is kept, and `res_ovf` is set.
  - Capture together with `res_ready`=1: the new result is loaded, with no overflow.
- FIFO: push on `in_valid`&&`in_ready`. `in_ready` = !full. Push and pop on the same edge are both honoured.
- Arithmetic: 3·(2^WIDTH−1)^2 < 2^RES_W. No truncation anywhere.

## Timing
- Reset values: `slot`=0, frame register=0, `real`=0, `done_real`=0, FIFO empty, `in_ready`=1, `tx_word`=0, `res_valid`=0, `res_data`=0, `res_ovf`=0, `chk_mismatch`=0.
- Both blocks share one reset event. The first frame after reset is therefore always filler.
- Reset mid-frame: the partial frame and all FIFO contents are lost. The consumer's reset-time `run` is ignored because `done_real`=0.
- Latency: for a pair loaded at frame-load edge E, its words appear in the 6 cycles after E. `cons_run` is seen in cycle E+7, and `res_valid` rises in cycle E+8.
- Throughput: one pair per 6 cycles.
- With the FIFO empty, a pair accepted in slot s<5 is loaded at the next frame-load edge. A pair accepted in slot 5 waits one further frame.

## Configuration
- `DOT_TX_CHECK_EN` defined:
  - At frame load, compute the expected dot product and carry it alongside `real` and `done_real`.
  - On capture, if `cons_dout` ≠ expected, set sticky `chk_mismatch`. The result is still delivered.
- Undefined: no reference multipliers are built and `chk_mismatch` is tied 0.

## Structure
- Package `dot_pkg` holds:
  - constants `DOT_WIDTH`=8, `DOT_NUM_ELEM`=3, `DOT_FRAME_LEN`=6, `DOT_RES_W`
  - typedef `dot_slot_t` (3-bit)
  - typedef `dot_pair_t` (struct of a and b arrays)
- Sub-module `dot_tx_fifo`: a synchronous FIFO of `dot_pair_t`, depth `FIFO_DEPTH`, with full/empty flags.

## Test plan
- Reset then idle for 24 cycles: `tx_word`=0 throughout, and `res_valid` stays 0 even though the consumer strobes `run` every frame.
- One pair a=(1,2,3), b=(4,5,6) accepted in slot 2: words 1,2,3,4,5,6 in the next frame; `res_data`=32 with `res_valid`=1 at E+8.
- Three back-to-back pairs with `FIFO_DEPTH`=2:
  - `in_ready` drops after two pushes.
  - Frames are contiguous with no filler between them.
  - Results come out in order.
- All elements 255, with `res_ready` held 0 for two results: first `res_data`=195075, second result dropped, `res_ovf`=1.
- Reset asserted in slot 3 of a real frame: afterwards `tx_word`=0, FIFO empty, and no result is delivered for the aborted pair.
- With `DOT_TX_CHECK_EN`, force the consumer's `cons_dout` to the expected value +1: `chk_mismatch` is set and `res_data` reflects the forced value.
